// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_share_arbiter: one alu shared by two valid/ready requesters (RR/fixed) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module alu #(
   parameter int ALU_WIDTH = 32
) (
   input  logic [3:0]           alusel,
   input  logic [ALU_WIDTH-1:0] a,
   input  logic [ALU_WIDTH-1:0] b,
   output logic [ALU_WIDTH-1:0] result
);
   localparam int c_shw = $clog2(ALU_WIDTH);

   logic [c_shw-1:0] w_sh;
   assign w_sh = b[c_shw-1:0];

   always_comb begin
      result = '0;
      case (alusel)
         4'b0000: result = a + b;
         4'b0001: result = a - b;
         4'b0010: result = a << w_sh;
         4'b0011: result = {{(ALU_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'b0100: result = {{(ALU_WIDTH-1){1'b0}}, (a < b)};
         4'b0101: result = a ^ b;
         4'b0110: result = a >> w_sh;
         4'b0111: result = $signed(a) >>> w_sh;
         4'b1000: result = a | b;
         4'b1001: result = a & b;
         default: result = '0;
      endcase
   end
endmodule

module alu_share_arbiter #(
   parameter int ALU_WIDTH = 32,
   parameter int RR_ENABLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [3:0]           req0_op,
   input  logic [ALU_WIDTH-1:0] req0_a,
   input  logic [ALU_WIDTH-1:0] req0_b,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [3:0]           req1_op,
   input  logic [ALU_WIDTH-1:0] req1_a,
   input  logic [ALU_WIDTH-1:0] req1_b,
   output logic                 rsp0_valid,
   input  logic                 rsp0_ready,
   output logic [ALU_WIDTH-1:0] rsp0_result,
   output logic                 rsp1_valid,
   input  logic                 rsp1_ready,
   output logic [ALU_WIDTH-1:0] rsp1_result,
   output logic                 busy
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_g;
   logic                 r_last;
   logic [3:0]           r_op;
   logic [ALU_WIDTH-1:0] r_a;
   logic [ALU_WIDTH-1:0] r_b;
   logic [ALU_WIDTH-1:0] r_res;

   logic                 w_pick1;
   logic                 w_idle_ok;
   logic                 w_req_hs;
   logic                 w_rsp_on;
   logic                 w_rsp_hs;
   logic [ALU_WIDTH-1:0] w_alu_res;

   // Port 1 wins when alone, or on a tie when round-robin says port 0 went last.
   assign w_pick1   = req1_valid && (!req0_valid || ((RR_ENABLE != 0) && !r_last));
   assign w_idle_ok = !rst && (r_state == IDLE);
   assign req0_ready = w_idle_ok && req0_valid && !w_pick1;
   assign req1_ready = w_idle_ok && w_pick1;
   assign w_req_hs  = req0_ready || req1_ready;

   // Gating with rst keeps every handshake output quiet while reset is held.
   assign w_rsp_on    = !rst && (r_state == RESP);
   assign rsp0_valid  = w_rsp_on && !r_g;
   assign rsp1_valid  = w_rsp_on && r_g;
   assign rsp0_result = rsp0_valid ? r_res : '0;
   assign rsp1_result = rsp1_valid ? r_res : '0;
   assign w_rsp_hs    = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
   assign busy        = !rst && (r_state != IDLE);

   alu #(
      .ALU_WIDTH (ALU_WIDTH)
   ) u_alu (
      .alusel (r_op),
      .a      (r_a),
      .b      (r_b),
      .result (w_alu_res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_g     <= 1'b0;
         r_last  <= 1'b1;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req_hs) begin
                  r_g     <= w_pick1;
                  r_last  <= w_pick1;
                  r_op    <= w_pick1 ? req1_op : req0_op;
                  r_a     <= w_pick1 ? req1_a  : req0_a;
                  r_b     <= w_pick1 ? req1_b  : req0_b;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_res   <= w_alu_res;
               r_state <= RESP;
            end
            RESP: begin
               if (w_rsp_hs) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// Randomized bench for alu_share_arbiter against a transaction-level reference model.
module tb_alu_share_arbiter;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
   logic [3:0]   req0_op = 0, req1_op = 0;
   logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
   logic [W-1:0] rsp0_result, rsp1_result;

   // Fixed-priority instance: both ports always requesting.
   logic         f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_busy;
   logic [W-1:0] f_rsp0_result, f_rsp1_result;

   alu_share_arbiter #(.ALU_WIDTH(W), .RR_ENABLE(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .busy(busy)
   );

   alu_share_arbiter #(.ALU_WIDTH(W), .RR_ENABLE(0)) dut_fp (
      .clk(clk), .rst(rst),
      .req0_valid(1'b1), .req0_ready(f_req0_ready), .req0_op(4'd0), .req0_a(32'd5), .req0_b(32'd7),
      .req1_valid(1'b1), .req1_ready(f_req1_ready), .req1_op(4'd0), .req1_a(32'd100), .req1_b(32'd1),
      .rsp0_valid(f_rsp0_valid), .rsp0_ready(1'b1), .rsp0_result(f_rsp0_result),
      .rsp1_valid(f_rsp1_valid), .rsp1_ready(1'b1), .rsp1_result(f_rsp1_result),
      .busy(f_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      int sh;
      sh = int'(b % W);
      case (op)
         4'd0: r = a + b;
         4'd1: r = a - b;
         4'd2: r = a << sh;
         4'd3: r = ($signed(a) < $signed(b)) ? 1 : 0;
         4'd4: r = (a < b) ? 1 : 0;
         4'd5: r = a ^ b;
         4'd6: r = a >> sh;
         4'd7: r = $signed(a) >>> sh;
         4'd8: r = a | b;
         4'd9: r = a & b;
         default: r = 0;
      endcase
      return r;
   endfunction

   // Reference: phase 0 = free, 1 = op accepted last cycle, 2 = result owed to port m_g.
   int           m_phase = 0;
   int           m_g     = 0;
   int           m_last  = 1;
   logic [W-1:0] m_res   = 0;
   int           order[$];
   int           f_cnt = 0;

   function automatic int winner(input logic v0, input logic v1, input int last);
      if (v0 && v1) return (last == 1) ? 0 : 1;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic model_check();
      logic on;
      logic r0, r1;
      int w;
      on = !rst;
      w  = winner(req0_valid, req1_valid, m_last);
      r0 = on && m_phase == 2 && m_g == 0;
      r1 = on && m_phase == 2 && m_g == 1;
      check("busy",        busy,        W'(on && m_phase != 0));
      check("req0_ready",  req0_ready,  W'(on && m_phase == 0 && w == 0));
      check("req1_ready",  req1_ready,  W'(on && m_phase == 0 && w == 1));
      check("rsp0_valid",  rsp0_valid,  W'(r0));
      check("rsp1_valid",  rsp1_valid,  W'(r1));
      check("rsp0_result", rsp0_result, r0 ? m_res : '0);
      check("rsp1_result", rsp1_result, r1 ? m_res : '0);
      check("fp_rsp1_valid", f_rsp1_valid, '0);
      if (f_rsp0_valid === 1'b1) begin
         check("fp_rsp0_result", f_rsp0_result, 32'd12);
         f_cnt++;
      end
      if (rsp0_valid === 1'b1) order.push_back(0);
      if (rsp1_valid === 1'b1) order.push_back(1);
   endtask

   task automatic model_update();
      int w;
      if (rst) begin
         m_phase = 0;
         m_last  = 1;
      end else begin
         case (m_phase)
            0: begin
               w = winner(req0_valid, req1_valid, m_last);
               if (w >= 0) begin
                  m_g     = w;
                  m_last  = w;
                  m_res   = (w == 1) ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
                  m_phase = 1;
               end
            end
            1: m_phase = 2;
            default: if ((m_g == 1) ? rsp1_ready : rsp0_ready) m_phase = 0;
         endcase
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      repeat (3) step();
      rst = 1'b0;
      rsp0_ready = 1; rsp1_ready = 1;

      // T1: port 0 ADD
      req0_valid = 1; req0_op = 4'd0; req0_a = 32'hEEFF4567; req0_b = 32'hFFFF5656;
      step();
      req0_valid = 0;
      step();
      #2;
      check("t1_valid", rsp0_valid, 1);
      check("t1_res", rsp0_result, 32'hEEFE9BBD);
      step(); step();

      // T2: port 1 SUB
      req1_valid = 1; req1_op = 4'd1; req1_a = 32'hEEFF4567; req1_b = 32'hFFFF5656;
      step();
      req1_valid = 0;
      step();
      #2;
      check("t2_res", rsp1_result, 32'hEEFFEF11);
      check("t2_rsp0_quiet", rsp0_valid, 0);
      step(); step();

      // T3: continuous contention from reset
      do_reset();
      order.delete();
      f_cnt = 0;
      req0_valid = 1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
      req1_valid = 1; req1_op = 4'd8; req1_a = 32'hF0; req1_b = 32'h0F;
      repeat (12) step();
      check("t3_count", order.size(), 4);
      for (int i = 0; i < order.size() && i < 4; i++)
         check($sformatf("t3_order%0d", i), order[i], (i % 2));
      check("t3_fp_count", f_cnt, 4);

      // T4: stalled response
      do_reset();
      rsp0_ready = 0;
      req0_a = 32'h1234; req0_b = 32'h1111;
      step(); step();
      repeat (5) step();
      #2;
      check("t4_busy", busy, 1);
      check("t4_res", rsp0_result, 32'h2345);
      check("t4_rdy0", req0_ready, 0);
      check("t4_rdy1", req1_ready, 0);
      rsp0_ready = 1;
      step();
      #2;
      check("t4_resume", req1_ready, 1);
      step();
      req0_valid = 0; req1_valid = 0;
      repeat (4) step();

      // T5: reset during EXEC
      req0_valid = 1; req0_op = 4'd0; req0_a = 32'd9; req0_b = 32'd9;
      step();
      req0_valid = 0;
      rst = 1;
      step();
      rst = 0;
      #2;
      check("t5_idle", busy, 0);
      repeat (3) step();
      req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2;
      step();
      req0_valid = 0;
      step();
      #2;
      check("t5_res", rsp0_result, 32'h3);
      step(); step();

      // T6: operands change after the handshake
      req0_valid = 1; req0_op = 4'd0; req0_a = 32'd10; req0_b = 32'd20;
      step();
      req0_valid = 0; req0_a = 32'hFFFF_0000; req0_b = 32'h0000_FFFF;
      step();
      #2;
      check("t6_res", rsp0_result, 32'd30);
      step(); step();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         rst        = ($urandom_range(99) == 0);
         req0_valid = $urandom_range(1);
         req1_valid = $urandom_range(1);
         rsp0_ready = ($urandom_range(9) < 6);
         rsp1_ready = ($urandom_range(9) < 6);
         req0_op = 4'($urandom_range(9));
         req1_op = 4'($urandom_range(9));
         req0_a = $urandom; req0_b = $urandom;
         req1_a = $urandom; req1_b = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
